// File: rtl/display_ocupacion.sv
// Seven-segment occupancy display: decodes the 3-bit lot count, flashes the
// decimal point after each change and blinks the digit while the lot is full.
module display_ocupacion #(
  parameter int TICK_DIV       = 6000000,
  parameter int FLASH_TICKS    = 2,
  parameter int FULL_VAL       = 7,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] count,
  output logic [6:0] seg,
  output logic       dp,
  output logic       full,
  output logic       empty
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int FC_W  = $clog2(FLASH_TICKS + 1);

  typedef enum logic [1:0] {ST_NORMAL, ST_FLASH, ST_FULL} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         count_q_reg;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic               blink_reg, blink_next;
  logic [FC_W-1:0]    flash_cnt_reg, flash_cnt_next;

  logic               chg, tick, go_full;
  logic [6:0]         dec, seg_next;
  logic               dp_next, full_next, empty_next;
  logic [6:0]         seg_reg;
  logic               dp_reg, full_reg, empty_reg;

  assign chg     = (count != count_q_reg);
  assign tick    = (div_reg == DIV_W'(TICK_DIV - 1));
  assign go_full = chg && (count >= 3'(FULL_VAL));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_NORMAL;
      count_q_reg   <= 3'd0;
      div_reg       <= '0;
      blink_reg     <= 1'b0;
      flash_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      count_q_reg   <= count;
      div_reg       <= div_next;
      blink_reg     <= blink_next;
      flash_cnt_reg <= flash_cnt_next;
    end
  end

  // A count change always wins over a tick arriving in the same cycle.
  always_comb begin
    state_next     = state_reg;
    flash_cnt_next = flash_cnt_reg;
    div_next       = tick ? '0 : div_reg + DIV_W'(1);
    blink_next     = go_full ? 1'b0 : (tick ? ~blink_reg : blink_reg);
    if (chg) begin
      if (go_full) begin
        state_next = ST_FULL;
      end else begin
        state_next     = ST_FLASH;
        flash_cnt_next = FC_W'(FLASH_TICKS);
      end
    end else if (state_reg == ST_FLASH && tick) begin
      if (flash_cnt_reg == FC_W'(1)) begin
        state_next     = ST_NORMAL;
        flash_cnt_next = '0;
      end else begin
        flash_cnt_next = flash_cnt_reg - FC_W'(1);
      end
    end
  end

  always_comb begin
    dec = 7'b0111111;
    case (count_q_reg)
      3'd0: dec = 7'b0111111;
      3'd1: dec = 7'b0000110;
      3'd2: dec = 7'b1011011;
      3'd3: dec = 7'b1001111;
      3'd4: dec = 7'b1100110;
      3'd5: dec = 7'b1101101;
      3'd6: dec = 7'b1111101;
      3'd7: dec = 7'b0000111;
      default: dec = 7'b0111111;
    endcase
    seg_next   = ((state_reg == ST_FULL) && blink_reg) ? 7'b0000000 : dec;
    seg_next   = seg_next ^ {7{SEG_ACTIVE_LOW}};
    dp_next    = (state_reg == ST_FLASH) ^ SEG_ACTIVE_LOW;
    full_next  = (state_reg == ST_FULL);
    empty_next = (count_q_reg == 3'd0);
  end

  // Outputs track the cleared state, so they need no reset of their own.
  always_ff @(posedge clk) begin
    seg_reg   <= seg_next;
    dp_reg    <= dp_next;
    full_reg  <= full_next;
    empty_reg <= empty_next;
  end

  assign seg   = seg_reg;
  assign dp    = dp_reg;
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: tb/tb_display_ocupacion.sv
// Randomized check of display_ocupacion in two configurations against a
// model that derives flash/blink phase from tick counts since the last change.
module tb_display_ocupacion;

  localparam int TD0 = 4, FT0 = 2, FV0 = 7;
  localparam int TD1 = 3, FT1 = 3, FV1 = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] count = 3'd0;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, full0, full1, empty0, empty1;

  always #5 clk = ~clk;

  display_ocupacion #(.TICK_DIV(TD0), .FLASH_TICKS(FT0), .FULL_VAL(FV0), .SEG_ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .reset(reset), .count(count),
    .seg(seg0), .dp(dp0), .full(full0), .empty(empty0));

  display_ocupacion #(.TICK_DIV(TD1), .FLASH_TICKS(FT1), .FULL_VAL(FV1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .reset(reset), .count(count),
    .seg(seg1), .dp(dp1), .full(full1), .empty(empty1));

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model: edges since reset, edge of last change and whether it reached FULL.
  int         k_m[2], e_m[2];
  logic [2:0] cq_m[2];
  bit         has_m[2], efull_m[2], valid_m[2];
  bit         exp_ok[2];
  logic [9:0] exp_v[2];

  function automatic logic [6:0] decode(input logic [2:0] v);
    logic [6:0] tbl[8];
    tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111};
    return tbl[v];
  endfunction

  function automatic logic [9:0] predict(input int i);
    int td, ft, ticks;
    bit inv, in_full, in_flash, blank;
    logic [6:0] s;
    td = (i == 0) ? TD0 : TD1;
    ft = (i == 0) ? FT0 : FT1;
    inv = (i == 1);
    ticks = k_m[i] / td - e_m[i] / td;
    in_full  = has_m[i] && efull_m[i];
    in_flash = has_m[i] && !efull_m[i] && (ticks < ft);
    blank    = in_full && (ticks % 2 == 1);
    s = blank ? 7'b0000000 : decode(cq_m[i]);
    if (inv) s = ~s;
    return {s, in_flash ^ inv, in_full, cq_m[i] == 3'd0};
  endfunction

  task automatic model_step(input int i);
    int fv;
    fv = (i == 0) ? FV0 : FV1;
    exp_ok[i] = valid_m[i];
    exp_v[i]  = predict(i);
    if (reset) begin
      k_m[i] = 0; e_m[i] = 0; cq_m[i] = 3'd0;
      has_m[i] = 1'b0; efull_m[i] = 1'b0; valid_m[i] = 1'b1;
    end else begin
      k_m[i]++;
      if (count != cq_m[i]) begin
        has_m[i] = 1'b1;
        e_m[i] = k_m[i];
        efull_m[i] = (int'(count) >= fv);
      end
      cq_m[i] = count;
    end
  endtask

  task automatic compare_all();
    logic [9:0] g[2];
    g[0] = {seg0, dp0, full0, empty0};
    g[1] = {seg1, dp1, full1, empty1};
    for (int i = 0; i < 2; i++) begin
      if (exp_ok[i]) begin
        check($sformatf("seg%0d", i),   {1'b0, g[i][9:3]}, {1'b0, exp_v[i][9:3]});
        check($sformatf("dp%0d", i),    {7'b0, g[i][2]},   {7'b0, exp_v[i][2]});
        check($sformatf("full%0d", i),  {7'b0, g[i][1]},   {7'b0, exp_v[i][1]});
        check($sformatf("empty%0d", i), {7'b0, g[i][0]},   {7'b0, exp_v[i][0]});
      end
    end
  endtask

  task automatic apply(input logic r, input logic [2:0] c, input int cycles);
    if (r != reset || c != count) begin
      n_txn++;
      $display("txn %0d: reset=%0b count %0d -> %0d for %0d cycles", n_txn, r, count, c, cycles);
    end
    reset = r;
    count = c;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      valid_m[i] = 1'b0; exp_ok[i] = 1'b0; k_m[i] = 0; e_m[i] = 0;
      cq_m[i] = 3'd0; has_m[i] = 1'b0; efull_m[i] = 1'b0; exp_v[i] = '0;
    end
    @(negedge clk);
    apply(1'b1, 3'd0, 3);
    apply(1'b0, 3'd0, 20);
    apply(1'b0, 3'd3, 12);
    apply(1'b0, 3'd4, 3);
    apply(1'b0, 3'd5, 12);
    apply(1'b0, 3'd6, 10);
    apply(1'b0, 3'd7, 20);
    apply(1'b0, 3'd6, 12);
    apply(1'b0, 3'd7, 7);
    apply(1'b1, 3'd7, 1);
    apply(1'b0, 3'd7, 12);
    for (int t = 0; t < 300; t++) begin
      logic       r;
      logic [2:0] c;
      r = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 3) == 0) ? count : 3'($urandom_range(0, 7));
      apply(r, c, r ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 14)));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
